// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock show-ahead FIFO with occupancy count,
// full/empty/almost flags and sticky overflow/underflow error flags.
//
// Ports:
//   CLK      input   1          rising-edge clock
//   CLR_N    input   1          synchronous active-low reset
//   PUSH     input   1          write request
//   POP      input   1          read request
//   D        input   W          write data
//   ERR_CLR  input   1          clears OVF/UNF (a same-cycle set wins)
//   Q        output  W          head-of-queue data, zero when empty
//   CNT      output  DEPTH_W+1  occupancy 0..DEPTH
//   FULL, EMPTY, AFULL, AEMPTY  output  status decodes of CNT
//   OVF, UNF output  1          sticky overflow / underflow
module sync_fifo_flags #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH_W = 4,
  parameter int unsigned AF_LVL  = (2 ** DEPTH_W) - 2,
  parameter int unsigned AE_LVL  = 1
) (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               PUSH,
  input  logic               POP,
  input  logic [W-1:0]       D,
  input  logic               ERR_CLR,
  output logic [W-1:0]       Q,
  output logic [DEPTH_W:0]   CNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               AFULL,
  output logic               AEMPTY,
  output logic               OVF,
  output logic               UNF
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;
  localparam int unsigned CW    = DEPTH_W + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LVL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LVL);

  logic [W-1:0]       r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wp;
  logic [DEPTH_W-1:0] r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf;
  logic               r_unf;

  logic               w_full;
  logic               w_empty;
  logic               w_pop_ok;
  logic               w_push_ok;
  logic               w_ovf_set;
  logic               w_unf_set;

  // Status decodes straight off the registered count.
  assign w_full  = (r_cnt == C_DEPTH);
  assign w_empty = (r_cnt == '0);

  // A push into a full FIFO is still accepted when a pop frees a slot on the
  // same edge; a pop from an empty FIFO never is (no bypass path).
  assign w_pop_ok  = POP & ~w_empty;
  assign w_push_ok = PUSH & (~w_full | w_pop_ok);
  assign w_ovf_set = PUSH & w_full & ~POP;
  assign w_unf_set = POP & w_empty;

  // Storage array; not reset, but writes are blocked while CLR_N is low.
  always_ff @(posedge CLK) begin
    if (CLR_N && w_push_ok) begin
      r_mem[r_wp] <= D;
    end
  end

  // Pointers and count; pointers wrap by natural modulo arithmetic.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_wp <= r_wp + DEPTH_W'(1);
      end
      if (w_pop_ok) begin
        r_rp <= r_rp + DEPTH_W'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Sticky error flags; a set condition outranks ERR_CLR.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~ERR_CLR);
      r_unf <= w_unf_set | (r_unf & ~ERR_CLR);
    end
  end

  assign Q      = w_empty ? '0 : r_mem[r_rp];
  assign CNT    = r_cnt;
  assign FULL   = w_full;
  assign EMPTY  = w_empty;
  assign AFULL  = (r_cnt >= C_AF);
  assign AEMPTY = (r_cnt <= C_AE);
  assign OVF    = r_ovf;
  assign UNF    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int unsigned W       = 8;
  localparam int unsigned DEPTH_W = 2;

  logic             CLK;
  logic             CLR_N;
  logic             PUSH;
  logic             POP;
  logic [W-1:0]     D;
  logic             ERR_CLR;
  logic [W-1:0]     Q;
  logic [DEPTH_W:0] CNT;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic             OVF;
  logic             UNF;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_flags #(
    .W       (W),
    .DEPTH_W (DEPTH_W),
    .AF_LVL  (3),
    .AE_LVL  (1)
  ) u_dut (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .PUSH    (PUSH),
    .POP     (POP),
    .D       (D),
    .ERR_CLR (ERR_CLR),
    .Q       (Q),
    .CNT     (CNT),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .AFULL   (AFULL),
    .AEMPTY  (AEMPTY),
    .OVF     (OVF),
    .UNF     (UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given request inputs, then sample 1 ns later.
  task automatic cyc(input logic push, input logic pop, input logic [W-1:0] d, input logic clr);
    PUSH = push; POP = pop; D = d; ERR_CLR = clr;
    @(posedge CLK);
    #1;
    PUSH = 1'b0; POP = 1'b0; D = '0; ERR_CLR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_q;
    CLR_N = 1'b0; PUSH = 1'b0; POP = 1'b0; D = '0; ERR_CLR = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CLR_N = 1'b1;

    // Reset state
    check("rst_cnt", 16'(CNT), 16'd0);
    check("rst_empty", 16'(EMPTY), 16'd1);
    check("rst_full", 16'(FULL), 16'd0);
    check("rst_aempty", 16'(AEMPTY), 16'd1);
    check("rst_afull", 16'(AFULL), 16'd0);
    check("rst_q", 16'(Q), 16'h0);
    check("rst_ovf", 16'(OVF), 16'd0);
    check("rst_unf", 16'(UNF), 16'd0);

    // Fill
    cyc(1, 0, 8'h11, 0);
    check("f1_cnt", 16'(CNT), 16'd1);
    check("f1_aempty", 16'(AEMPTY), 16'd1);
    check("f1_q", 16'(Q), 16'h11);
    cyc(1, 0, 8'h22, 0);
    check("f2_aempty", 16'(AEMPTY), 16'd0);
    check("f2_afull", 16'(AFULL), 16'd0);
    cyc(1, 0, 8'h33, 0);
    check("f3_afull", 16'(AFULL), 16'd1);
    check("f3_full", 16'(FULL), 16'd0);
    cyc(1, 0, 8'h44, 0);
    check("f4_cnt", 16'(CNT), 16'd4);
    check("f4_full", 16'(FULL), 16'd1);
    check("f4_afull", 16'(AFULL), 16'd1);

    // Overflow, then clear; then set-versus-clear priority
    cyc(1, 0, 8'h55, 0);
    check("ovf_cnt", 16'(CNT), 16'd4);
    check("ovf_flag", 16'(OVF), 16'd1);
    check("ovf_head", 16'(Q), 16'h11);
    cyc(0, 0, 8'h00, 1);
    check("ovf_clr", 16'(OVF), 16'd0);
    cyc(1, 0, 8'h56, 1);
    check("ovf_prio", 16'(OVF), 16'd1);
    cyc(0, 0, 8'h00, 1);
    check("ovf_clr2", 16'(OVF), 16'd0);

    // Drain in order
    check("d1_q", 16'(Q), 16'h11);
    cyc(0, 1, 8'h00, 0);
    check("d2_q", 16'(Q), 16'h22);
    cyc(0, 1, 8'h00, 0);
    check("d3_q", 16'(Q), 16'h33);
    cyc(0, 1, 8'h00, 0);
    check("d4_q", 16'(Q), 16'h44);
    cyc(0, 1, 8'h00, 0);
    check("dr_empty", 16'(EMPTY), 16'd1);
    check("dr_q", 16'(Q), 16'h0);
    check("dr_unf", 16'(UNF), 16'd0);

    // Underflow with simultaneous push into empty
    cyc(1, 1, 8'h66, 0);
    check("unf_flag", 16'(UNF), 16'd1);
    check("unf_cnt", 16'(CNT), 16'd1);
    check("unf_q", 16'(Q), 16'h66);
    cyc(0, 0, 8'h00, 1);
    check("unf_clr", 16'(UNF), 16'd0);
    cyc(0, 1, 8'h00, 0);
    check("unf_drain", 16'(EMPTY), 16'd1);

    // Wrap: occupancy held at 2 through 10 push/pop pairs
    cyc(1, 0, 8'hA0, 0);
    cyc(1, 0, 8'hA1, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q = (i == 0) ? 8'hA0 : (i == 1) ? 8'hA1 : 8'(i - 2);
      check("wrap_q", 16'(Q), 16'(exp_q));
      cyc(1, 1, 8'(i), 0);
      check("wrap_cnt", 16'(CNT), 16'd2);
      check("wrap_err", 16'({OVF, UNF}), 16'd0);
    end
    check("wrap_t0", 16'(Q), 16'h08);
    cyc(0, 1, 8'h00, 0);
    check("wrap_t1", 16'(Q), 16'h09);
    cyc(0, 1, 8'h00, 0);
    check("wrap_empty", 16'(EMPTY), 16'd1);

    // Simultaneous push+pop while full
    cyc(1, 0, 8'hB0, 0);
    cyc(1, 0, 8'hB1, 0);
    cyc(1, 0, 8'hB2, 0);
    cyc(1, 0, 8'hB3, 0);
    cyc(1, 1, 8'hAA, 0);
    check("fs_cnt", 16'(CNT), 16'd4);
    check("fs_ovf", 16'(OVF), 16'd0);
    check("fs_q1", 16'(Q), 16'hB1);
    cyc(0, 1, 8'h00, 0);
    check("fs_q2", 16'(Q), 16'hB2);
    cyc(0, 1, 8'h00, 0);
    check("fs_q3", 16'(Q), 16'hB3);
    cyc(0, 1, 8'h00, 0);
    check("fs_q4", 16'(Q), 16'hAA);
    cyc(0, 1, 8'h00, 0);
    check("fs_empty", 16'(EMPTY), 16'd1);

    // Reset mid-operation with CNT=3, OVF=1
    cyc(1, 0, 8'hC0, 0);
    cyc(1, 0, 8'hC1, 0);
    cyc(1, 0, 8'hC2, 0);
    cyc(1, 0, 8'hC3, 0);
    cyc(1, 0, 8'hC4, 0);
    cyc(0, 1, 8'h00, 0);
    check("pre_cnt", 16'(CNT), 16'd3);
    check("pre_ovf", 16'(OVF), 16'd1);
    CLR_N = 1'b0;
    cyc(1, 0, 8'hDD, 1);
    CLR_N = 1'b1;
    check("mr_cnt", 16'(CNT), 16'd0);
    check("mr_empty", 16'(EMPTY), 16'd1);
    check("mr_ovf", 16'(OVF), 16'd0);
    check("mr_q", 16'(Q), 16'h0);
    cyc(1, 0, 8'hEE, 0);
    check("post_cnt", 16'(CNT), 16'd1);
    check("post_q", 16'(Q), 16'hEE);
    cyc(1, 0, 8'hEF, 0);
    cyc(0, 1, 8'h00, 0);
    check("post_q2", 16'(Q), 16'hEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
